// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
//  Module   : riscv_mem_arbiter
//  Brief    : Two-requester (fetch / load-store) arbiter onto a single memory
//             port, one transaction outstanding, with timeout and fetch abort.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        inst_rd_i,
    input  logic [31:0] inst_pc_i,
    input  logic        inst_abort_i,
    output logic        inst_accept_o,
    output logic        inst_valid_o,
    output logic        inst_error_o,
    output logic [31:0] inst_data_o,

    input  logic        data_rd_i,
    input  logic [3:0]  data_wr_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_accept_o,
    output logic        data_ack_o,
    output logic        data_error_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_ISSUE      = 2'd1;
    localparam logic [1:0]  c_WAIT       = 2'd2;
    localparam logic        c_GRANT_INST = 1'b0;
    localparam logic        c_GRANT_DATA = 1'b1;
    localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic [15:0] r_cnt;
    logic        r_abort;
    logic        r_rd;
    logic [3:0]  r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_inst_valid;
    logic        r_inst_error;
    logic [31:0] r_inst_data;
    logic        r_data_ack;
    logic        r_data_error;
    logic [31:0] r_data_rdata;

    logic        w_inst_pend;
    logic        w_data_pend;
    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_can_grant;
    logic        w_issue;
    logic        w_wait;
    logic        w_busy;
    logic        w_ack;
    logic        w_timeout;
    logic        w_done;
    logic        w_abort_now;
    logic        w_suppress;
    logic [15:0] w_cnt_next;
    logic [31:0] w_rsp_data;
    logic        w_rsp_err;

    assign w_inst_pend  = inst_rd_i;
    assign w_data_pend  = data_rd_i | (|data_wr_i);
    // On a tie the side that did not win last time is served.
    assign w_grant_data = w_data_pend & (~w_inst_pend | (r_last_grant == c_GRANT_INST));
    assign w_grant_inst = w_inst_pend & ~w_grant_data;
    // Accepts are combinational, so they are also held low while in reset.
    assign w_can_grant  = (r_state == c_IDLE) & rst_i;

    assign inst_accept_o = w_can_grant & w_grant_inst;
    assign data_accept_o = w_can_grant & w_grant_data;

    assign w_issue    = (r_state == c_ISSUE);
    assign w_wait     = (r_state == c_WAIT);
    assign w_busy     = w_issue | w_wait;
    assign w_ack      = (w_issue & mem_accept_i & mem_ack_i) | (w_wait & mem_ack_i);
    assign w_cnt_next = r_cnt + 16'd1;
    assign w_timeout  = w_busy & ~w_ack & (w_cnt_next == c_TIMEOUT);
    assign w_done     = w_ack | w_timeout;
    assign w_rsp_data = w_ack ? mem_rdata_i : 32'h0;
    assign w_rsp_err  = w_ack ? mem_error_i : 1'b1;

    // An abort arriving together with the ack still suppresses the response.
    assign w_abort_now = inst_abort_i & w_busy & (r_owner == c_GRANT_INST);
    assign w_suppress  = r_abort | w_abort_now;

    assign mem_rd_o    = w_issue & r_rd;
    assign mem_wr_o    = w_issue ? r_wr : 4'h0;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    assign inst_valid_o = r_inst_valid;
    assign inst_error_o = r_inst_error;
    assign inst_data_o  = r_inst_data;
    assign data_ack_o   = r_data_ack;
    assign data_error_o = r_data_error;
    assign data_rdata_o = r_data_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= c_IDLE;
            r_owner      <= c_GRANT_INST;
            r_last_grant <= c_GRANT_INST;
            r_cnt        <= 16'h0;
            r_abort      <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 4'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_inst_valid <= 1'b0;
            r_inst_error <= 1'b0;
            r_inst_data  <= 32'h0;
            r_data_ack   <= 1'b0;
            r_data_error <= 1'b0;
            r_data_rdata <= 32'h0;
        end else begin
            r_inst_valid <= 1'b0;
            r_inst_error <= 1'b0;
            r_data_ack   <= 1'b0;
            r_data_error <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_data | w_grant_inst) begin
                        r_state      <= c_ISSUE;
                        r_owner      <= w_grant_data;
                        r_last_grant <= w_grant_data;
                        r_cnt        <= 16'h0;
                        r_abort      <= 1'b0;
                        if (w_grant_data) begin
                            r_rd    <= data_rd_i & ~(|data_wr_i);
                            r_wr    <= data_wr_i;
                            r_addr  <= data_addr_i;
                            r_wdata <= data_wdata_i;
                        end else begin
                            r_rd    <= 1'b1;
                            r_wr    <= 4'h0;
                            r_addr  <= inst_pc_i;
                            r_wdata <= 32'h0;
                        end
                    end
                end
                c_ISSUE, c_WAIT: begin
                    if (w_done) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 16'h0;
                        r_abort <= 1'b0;
                        if (r_owner == c_GRANT_DATA) begin
                            r_data_ack   <= 1'b1;
                            r_data_error <= w_rsp_err;
                            r_data_rdata <= w_rsp_data;
                        end else if (!w_suppress) begin
                            r_inst_valid <= 1'b1;
                            r_inst_error <= w_rsp_err;
                            r_inst_data  <= w_rsp_data;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_issue && mem_accept_i) begin
                            r_state <= c_WAIT;
                        end
                        if (w_abort_now) begin
                            r_abort <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// ============================================================================
//  Module   : tb_riscv_mem_arbiter
//  Brief    : Self-checking bench for riscv_mem_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_mem_arbiter;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_rd_i, inst_abort_i;
    logic [31:0] inst_pc_i;
    logic        inst_accept_o, inst_valid_o, inst_error_o;
    logic [31:0] inst_data_o;
    logic        data_rd_i;
    logic [3:0]  data_wr_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_accept_o, data_ack_o, data_error_o;
    logic [31:0] data_rdata_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_accept_i, mem_ack_i, mem_error_i;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    riscv_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_rd_i(inst_rd_i), .inst_pc_i(inst_pc_i), .inst_abort_i(inst_abort_i),
        .inst_accept_o(inst_accept_o), .inst_valid_o(inst_valid_o),
        .inst_error_o(inst_error_o), .inst_data_o(inst_data_o),
        .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_accept_o(data_accept_o),
        .data_ack_o(data_ack_o), .data_error_o(data_error_o), .data_rdata_o(data_rdata_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_error_i(mem_error_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the single outstanding transaction and the response state.
    logic        m_busy, m_owner, m_issued, m_abort, m_last, m_rd;
    int          m_age;
    logic [3:0]  m_wr;
    logic [31:0] m_addr, m_wdata;
    logic        e_iv, e_ie, e_da, e_de;
    logic [31:0] e_idata, e_ddata;
    logic        g_inst, g_data;

    logic        s_ia, s_da, s_mrd, s_iv, s_ie, s_dack, s_derr;
    logic [3:0]  s_mwr;
    logic [31:0] s_maddr, s_idata, s_ddata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_issued = 0; m_abort = 0; m_last = 0; m_rd = 0;
        m_age = 0; m_wr = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        e_iv = 0; e_ie = 0; e_da = 0; e_de = 0; e_idata = 32'h0; e_ddata = 32'h0;
    endtask

    // One clock cycle: compare at the negedge, advance the model at the posedge.
    task automatic step();
        logic ip, dp, gd, ok, err;
        logic [31:0] rdat;
        logic exp_rd;
        logic [3:0] exp_wr;
        @(negedge clk_i);
        if (!rst_i) model_reset();
        ip = inst_rd_i;
        dp = data_rd_i || (data_wr_i != 4'h0);
        gd = dp && (!ip || !m_last);
        exp_rd = m_busy && !m_issued && m_rd;
        exp_wr = (m_busy && !m_issued) ? m_wr : 4'h0;
        s_ia = inst_accept_o; s_da = data_accept_o; s_mrd = mem_rd_o; s_mwr = mem_wr_o;
        s_maddr = mem_addr_o; s_iv = inst_valid_o; s_ie = inst_error_o; s_idata = inst_data_o;
        s_dack = data_ack_o; s_derr = data_error_o; s_ddata = data_rdata_o;
        chk("inst_accept", inst_accept_o, rst_i && !m_busy && ip && !gd);
        chk("data_accept", data_accept_o, rst_i && !m_busy && gd);
        chk("mem_rd", mem_rd_o, exp_rd);
        chk("mem_wr", mem_wr_o, exp_wr);
        if (exp_rd || exp_wr != 4'h0) chk("mem_addr", mem_addr_o, m_addr);
        if (exp_wr != 4'h0) chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("inst_valid", inst_valid_o, e_iv);
        chk("inst_error", inst_error_o, e_ie);
        chk("inst_data", inst_data_o, e_idata);
        chk("data_ack", data_ack_o, e_da);
        chk("data_error", data_error_o, e_de);
        chk("data_rdata", data_rdata_o, e_ddata);
        @(posedge clk_i);
        g_inst = 0; g_data = 0;
        if (!rst_i) begin
            model_reset();
        end else begin
            e_iv = 0; e_ie = 0; e_da = 0; e_de = 0;
            if (m_busy) begin
                ok = 0;
                m_age++;
                if (!m_owner && inst_abort_i) m_abort = 1;
                if (!m_issued) begin
                    if (mem_accept_i) begin
                        m_issued = 1;
                        ok = mem_ack_i;
                    end
                end else begin
                    ok = mem_ack_i;
                end
                if (ok || m_age == TO) begin
                    rdat = ok ? mem_rdata_i : 32'h0;
                    err  = ok ? mem_error_i : 1'b1;
                    if (m_owner) begin
                        e_da = 1; e_de = err; e_ddata = rdat;
                    end else if (!m_abort) begin
                        e_iv = 1; e_ie = err; e_idata = rdat;
                    end
                    m_busy = 0; m_abort = 0;
                end
            end else if (ip || dp) begin
                m_busy = 1; m_owner = gd; m_last = gd; m_issued = 0; m_age = 0; m_abort = 0;
                if (gd) begin
                    m_rd = (data_wr_i == 4'h0); m_wr = data_wr_i;
                    m_addr = data_addr_i; m_wdata = data_wdata_i; g_data = 1;
                end else begin
                    m_rd = 1; m_wr = 4'h0; m_addr = inst_pc_i; m_wdata = 32'h0; g_inst = 1;
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        inst_rd_i = 0; inst_pc_i = 0; inst_abort_i = 0;
        data_rd_i = 0; data_wr_i = 0; data_addr_i = 0; data_wdata_i = 0;
        mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 0;
        repeat (2) step();
        rst_i = 1;
    endtask

    initial begin
        int dead;
        model_reset();
        g_inst = 0; g_data = 0; dead = 0;
        clear_inputs();
        rst_i = 0;
        // Requests during reset must not be accepted.
        inst_rd_i = 1; data_rd_i = 1;
        step();
        chk("lit_rst_inst_accept", s_ia, 0);
        chk("lit_rst_data_accept", s_da, 0);
        chk("lit_rst_mem_addr", s_maddr, 32'h0);
        do_reset();

        // Single fetch, memory accepts next cycle, acks two cycles later.
        inst_rd_i = 1; inst_pc_i = 32'h100;
        step(); chk("lit_f_accept", s_ia, 1);
        inst_rd_i = 0; mem_accept_i = 1;
        step(); chk("lit_f_mem_rd", s_mrd, 1); chk("lit_f_mem_addr", s_maddr, 32'h100);
        mem_accept_i = 0;
        step();
        mem_ack_i = 1; mem_rdata_i = 32'h13;
        step();
        mem_ack_i = 0;
        step(); chk("lit_f_valid", s_iv, 1); chk("lit_f_data", s_idata, 32'h13);
        chk("lit_f_error", s_ie, 0);
        step(); chk("lit_f_pulse_end", s_iv, 0); chk("lit_f_data_hold", s_idata, 32'h13);

        // Tie after reset: data first, then strict alternation.
        do_reset();
        inst_rd_i = 1; inst_pc_i = 32'h200; data_rd_i = 1; data_addr_i = 32'h3000;
        mem_accept_i = 1; mem_ack_i = 1; mem_rdata_i = 32'h77;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("lit_tie_data_accept", s_da, (k % 2) == 0);
            chk("lit_tie_inst_accept", s_ia, (k % 2) == 1);
            step();
        end
        clear_inputs();
        step();

        // Store with a read strobe also present is a write.
        data_rd_i = 1; data_wr_i = 4'b0011; data_addr_i = 32'h2000; data_wdata_i = 32'hCAFEBABE;
        step(); chk("lit_st_accept", s_da, 1);
        data_rd_i = 0; data_wr_i = 0; mem_accept_i = 1;
        step(); chk("lit_st_mem_wr", s_mwr, 4'b0011); chk("lit_st_mem_rd", s_mrd, 0);
        chk("lit_st_addr", s_maddr, 32'h2000);
        mem_accept_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h0;
        step();
        mem_ack_i = 0;
        step(); chk("lit_st_ack", s_dack, 1); chk("lit_st_err", s_derr, 0);

        // Timeout with memory never accepting.
        do_reset();
        inst_rd_i = 1; inst_pc_i = 32'h400;
        step(); chk("lit_to_accept", s_ia, 1);
        inst_rd_i = 0;
        for (int k = 0; k < TO; k++) begin
            step(); chk("lit_to_mem_rd_held", s_mrd, 1);
        end
        step(); chk("lit_to_valid", s_iv, 1); chk("lit_to_err", s_ie, 1);
        chk("lit_to_data", s_idata, 32'h0); chk("lit_to_mem_rd_drop", s_mrd, 0);

        // Abort during WAIT, then a normal fetch, then abort coincident with ack.
        inst_rd_i = 1; inst_pc_i = 32'hFACEBEEF;
        step();
        inst_rd_i = 0; mem_accept_i = 1;
        step();
        mem_accept_i = 0; inst_abort_i = 1;
        step();
        inst_abort_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
        step();
        mem_ack_i = 0;
        step(); chk("lit_ab_no_valid", s_iv, 0); chk("lit_ab_data_hold", s_idata, 32'h0);
        inst_rd_i = 1; inst_pc_i = 32'h104;
        step();
        inst_rd_i = 0; mem_accept_i = 1; mem_ack_i = 1; mem_rdata_i = 32'h55;
        step();
        mem_accept_i = 0; mem_ack_i = 0;
        step(); chk("lit_ab_next_valid", s_iv, 1); chk("lit_ab_next_data", s_idata, 32'h55);
        inst_rd_i = 1; inst_pc_i = 32'h108;
        step();
        inst_rd_i = 0; mem_accept_i = 1; mem_ack_i = 1; inst_abort_i = 1; mem_rdata_i = 32'h66;
        step();
        mem_accept_i = 0; mem_ack_i = 0; inst_abort_i = 0;
        step(); chk("lit_ab_same_cycle", s_iv, 0);

        // Error pass-through, then reset while waiting for a response.
        data_rd_i = 1; data_addr_i = 32'h10;
        step();
        data_rd_i = 0; mem_accept_i = 1; mem_ack_i = 1; mem_error_i = 1; mem_rdata_i = 32'hA5;
        step();
        mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0;
        step(); chk("lit_err_ack", s_dack, 1); chk("lit_err_flag", s_derr, 1);
        chk("lit_err_data", s_ddata, 32'hA5);
        data_wr_i = 4'hF; data_addr_i = 32'h20; data_wdata_i = 32'h1234;
        step();
        data_wr_i = 0; mem_accept_i = 1;
        step();
        mem_accept_i = 0; mem_ack_i = 1;
        rst_i = 0;
        #1;
        chk("lit_arst_rdata", data_rdata_o, 32'h0);
        chk("lit_arst_idata", inst_data_o, 32'h0);
        chk("lit_arst_mem_wr", mem_wr_o, 4'h0);
        step(); step();
        rst_i = 1; mem_ack_i = 0;
        for (int k = 0; k < 3; k++) begin
            step(); chk("lit_arst_no_pulse", s_dack, 0);
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step();
            if (g_inst) inst_rd_i = 0;
            if (g_data) begin data_rd_i = 0; data_wr_i = 4'h0; end
            if (g_inst || g_data) dead = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (!inst_rd_i && $urandom_range(0, 2) == 0) begin
                inst_rd_i = 1; inst_pc_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_rd_i && data_wr_i == 4'h0 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: data_rd_i = 1;
                    1: data_wr_i = 4'($urandom_range(1, 15));
                    default: begin data_rd_i = 1; data_wr_i = 4'($urandom_range(1, 15)); end
                endcase
                data_addr_i = $urandom; data_wdata_i = $urandom;
            end
            inst_abort_i = ($urandom_range(0, 11) == 0);
            mem_rdata_i  = $urandom;
            mem_error_i  = ($urandom_range(0, 7) == 0);
            if (m_busy && !m_issued) begin
                mem_accept_i = (dead != 1) && ($urandom_range(0, 2) != 0);
                mem_ack_i    = mem_accept_i && (dead == 0) && ($urandom_range(0, 2) == 0);
            end else if (m_busy) begin
                mem_accept_i = ($urandom_range(0, 3) == 0);
                mem_ack_i    = (dead == 0) && ($urandom_range(0, 1) == 0);
            end else begin
                mem_accept_i = ($urandom_range(0, 3) == 0);
                mem_ack_i    = ($urandom_range(0, 15) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
